// File: rtl/conv_post_relu_pool.sv
// conv_post_relu_pool: bias + ReLU + rounding requantization of channel-summed
// convolution results, followed by 2x2 stride-2 max-pooling over a raster
// ordered feature map, using a half-row buffer for the even row of each pair.
module conv_post_relu_pool #(
    parameter int ACC_WIDTH  = 32,
    parameter int DATA_WIDTH = 8,
    parameter int BIAS_WIDTH = 16,
    parameter int FMAP_W     = 220
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame_start,
    input  logic signed [BIAS_WIDTH-1:0] bias,
    input  logic [4:0]                   shift,
    input  logic                         in_valid,
    input  logic signed [ACC_WIDTH-1:0]  in_data,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_eol
);

    localparam int SUM_W  = ACC_WIDTH + 1;
    localparam int HALF_W = FMAP_W / 2;
    localparam int COL_W  = (FMAP_W > 1) ? $clog2(FMAP_W) : 1;
    localparam int ADDR_W = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(FMAP_W - 1);
    localparam logic [COL_W-1:0] EOL_COL  = COL_W'(2 * HALF_W - 1);
    localparam logic [SUM_W:0]   SAT_MAX  = {{(SUM_W + 1 - DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};
    localparam logic [SUM_W:0]   ONE_W    = {{SUM_W{1'b0}}, 1'b1};

    function automatic logic [DATA_WIDTH-1:0] max2(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Stage 1 state: requantized pixel and its valid
    logic [DATA_WIDTH-1:0] q_data_q, q_data_d;
    logic                  q_valid_q;

    // Stage 2 state: position, pair register, row buffer, outputs
    logic [COL_W-1:0]      col_q, col_d;
    logic                  row_q, row_d;
    logic [DATA_WIDTH-1:0] p_q, p_d;
    logic [DATA_WIDTH-1:0] rowbuf_q [HALF_W];
    logic                  out_valid_d, out_eol_d;
    logic [DATA_WIDTH-1:0] out_data_d;

    logic signed [SUM_W-1:0] sum_s;
    logic [SUM_W:0]          half_s, rnd_s, shifted_s;
    logic [ADDR_W-1:0]       addr_s;
    logic [DATA_WIDTH-1:0]   h_s, rd_s;
    logic                    pool_col_s, wr_en_s;

    // Bias add at full width, ReLU, round-half-up right shift, saturate
    always_comb begin
        sum_s     = SUM_W'(in_data) + SUM_W'(bias);
        half_s    = '0;
        rnd_s     = '0;
        shifted_s = '0;
        q_data_d  = '0;
        if (sum_s[SUM_W-1]) begin
            q_data_d = '0;
        end else begin
            if (shift == 5'd0) begin
                rnd_s = {1'b0, sum_s};
            end else begin
                half_s = ONE_W << (shift - 5'd1);
                rnd_s  = {1'b0, sum_s} + half_s;
            end
            shifted_s = rnd_s >> shift;
            if (shifted_s > SAT_MAX) begin
                q_data_d = '1;
            end else begin
                q_data_d = shifted_s[DATA_WIDTH-1:0];
            end
        end
    end

    // Stage 1 register; a sample concurrent with frame_start is kept for the new frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_data_q  <= '0;
            q_valid_q <= 1'b0;
        end else begin
            q_data_q  <= q_data_d;
            q_valid_q <= in_valid;
        end
    end

    assign addr_s     = ADDR_W'(col_q >> 1);
    // With an odd width the trailing column never joins a pooling window
    assign pool_col_s = ((FMAP_W % 2) == 0) || (col_q != LAST_COL);
    assign h_s        = max2(p_q, q_data_q);
    assign rd_s       = rowbuf_q[addr_s];

    // Pooling next-state: column/row tracking, pair hold, row-buffer write, output
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        p_d         = p_q;
        wr_en_s     = 1'b0;
        out_valid_d = 1'b0;
        out_eol_d   = 1'b0;
        out_data_d  = out_data;
        if (frame_start) begin
            // The stage-1 sample still in flight belongs to the old frame
            col_d = '0;
            row_d = 1'b0;
            p_d   = '0;
        end else if (q_valid_q) begin
            if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = ~row_q;
            end else begin
                col_d = col_q + COL_W'(1);
                row_d = row_q;
            end
            if (!pool_col_s) begin
                p_d = p_q;
            end else if (!col_q[0]) begin
                p_d = q_data_q;
            end else if (!row_q) begin
                wr_en_s = 1'b1;
            end else begin
                out_valid_d = 1'b1;
                out_eol_d   = (col_q == EOL_COL);
                out_data_d  = max2(h_s, rd_s);
            end
        end else begin
            col_d = col_q;
        end
    end

    // Pooling state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q     <= '0;
            row_q     <= 1'b0;
            p_q       <= '0;
            out_valid <= 1'b0;
            out_eol   <= 1'b0;
            out_data  <= '0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            p_q       <= p_d;
            out_valid <= out_valid_d;
            out_eol   <= out_eol_d;
            out_data  <= out_data_d;
        end
    end

    // Half-row buffer holding the even-row horizontal maxima; contents need no reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            rowbuf_q[addr_s] <= h_s;
        end
    end

endmodule

// File: tb/tb_conv_post_relu_pool.sv
// Bench for conv_post_relu_pool: three instances (widths 4, 2, 5) share one
// stimulus stream; each is compared cycle by cycle against a window-based
// pooling model, plus directed end-of-scenario result lists.
module tb_conv_post_relu_pool;

    logic               clk;
    logic               rst;
    logic               frame_start;
    logic signed [15:0] bias;
    logic [4:0]         shift;
    logic               in_valid;
    logic [31:0]        in_data;
    logic [2:0]         ov;
    logic [2:0]         oe;
    logic [7:0]         od [3];

    int n_vec = 0;
    int n_err = 0;

    localparam int WID [3] = '{4, 2, 5};

    // model state
    int     mcol [3];
    int     mrow [3];
    int     top  [3][5];
    int     cur  [3][5];
    logic   stg_v;
    int     stg_q;
    logic   ev [3];
    logic   ee [3];
    int     ed [3];
    int     got[3][$];

    conv_post_relu_pool #(.ACC_WIDTH(32), .DATA_WIDTH(8), .BIAS_WIDTH(16), .FMAP_W(4)) u_w4 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .bias(bias), .shift(shift),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov[0]), .out_data(od[0]), .out_eol(oe[0]));

    conv_post_relu_pool #(.ACC_WIDTH(32), .DATA_WIDTH(8), .BIAS_WIDTH(16), .FMAP_W(2)) u_w2 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .bias(bias), .shift(shift),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov[1]), .out_data(od[1]), .out_eol(oe[1]));

    conv_post_relu_pool #(.ACC_WIDTH(32), .DATA_WIDTH(8), .BIAS_WIDTH(16), .FMAP_W(5)) u_w5 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .bias(bias), .shift(shift),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov[2]), .out_data(od[2]), .out_eol(oe[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int requant(input logic [31:0] d, input int b, input int sh);
        longint s;
        s = longint'($signed(d)) + longint'(b);
        if (s < 0) return 0;
        if (sh != 0) s = (s + (longint'(1) << (sh - 1))) >>> sh;
        if (s > 255) return 255;
        return int'(s);
    endfunction

    function automatic int mx(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            mcol[k] = 0;
            mrow[k] = 0;
        end
    endtask

    // Feed one requantized pixel into the pooling model of instance k
    task automatic model_pix(input int k, input int q);
        int c;
        int w;
        c = mcol[k];
        w = WID[k];
        if (mrow[k] == 0) begin
            top[k][c] = q;
        end else begin
            cur[k][c] = q;
            if ((c % 2 == 1) && (c < 2 * (w / 2))) begin
                ev[k] = 1'b1;
                ed[k] = mx(mx(top[k][c-1], top[k][c]), mx(cur[k][c-1], q));
                ee[k] = (c == 2 * (w / 2) - 1);
            end
        end
        mcol[k] = c + 1;
        if (mcol[k] == w) begin
            mcol[k] = 0;
            mrow[k] = 1 - mrow[k];
        end
    endtask

    // One clock cycle: drive inputs, predict this edge's outputs, sample and compare
    task automatic step(input logic fs, input logic v, input logic [31:0] d);
        frame_start = fs;
        in_valid    = v;
        in_data     = d;
        for (int k = 0; k < 3; k++) begin
            ev[k] = 1'b0;
            ee[k] = 1'b0;
            ed[k] = 0;
            if (stg_v && !fs) model_pix(k, stg_q);
        end
        if (fs) model_clear();
        stg_v = v;
        stg_q = requant(d, int'(bias), int'(shift));
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("out_valid w%0d", WID[k]), longint'(ov[k]), longint'(ev[k]));
            chk($sformatf("out_eol w%0d", WID[k]), longint'(oe[k]), longint'(ee[k]));
            if (ev[k]) chk($sformatf("out_data w%0d", WID[k]), longint'(od[k]), longint'(ed[k]));
            if (ov[k]) got[k].push_back(int'(od[k]));
        end
        frame_start = 1'b0;
        in_valid    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0);
    endtask

    task automatic feed(input int vals[$], input int maxgap);
        for (int i = 0; i < vals.size(); i++) begin
            if (maxgap > 0) idle($urandom_range(0, maxgap));
            step(1'b0, 1'b1, 32'(vals[i]));
        end
    endtask

    task automatic clear_got();
        for (int k = 0; k < 3; k++) got[k].delete();
    endtask

    task automatic chk_list(input string tag, input int k, input int exp[$]);
        chk({tag, " count"}, got[k].size(), exp.size());
        for (int i = 0; i < exp.size() && i < got[k].size(); i++)
            chk($sformatf("%s[%0d]", tag, i), got[k][i], exp[i]);
    endtask

    task automatic chk_zero(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s valid w%0d", tag, WID[k]), longint'(ov[k]), 0);
            chk($sformatf("%s data w%0d", tag, WID[k]), longint'(od[k]), 0);
            chk($sformatf("%s eol w%0d", tag, WID[k]), longint'(oe[k]), 0);
        end
    endtask

    task automatic four(input int v, input int b, input int sh, input int exp, input string tag);
        bias  = 16'(b);
        shift = 5'(sh);
        step(1'b1, 1'b0, 32'd0);
        clear_got();
        feed('{v, v, v, v}, 0);
        idle(3);
        chk_list(tag, 1, '{exp});
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; bias = 16'sd0; shift = 5'd0;
        in_valid = 1'b0; in_data = 32'd0; stg_v = 1'b0; stg_q = 0;
        model_clear();
        #1;
        chk_zero("reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // basic pooling, width 4
        step(1'b1, 1'b0, 32'd0);
        clear_got();
        feed('{1, 2, 3, 4, 5, 6, 7, 8}, 0);
        idle(3);
        chk_list("pool w4", 0, '{6, 8});

        // same stream with idle gaps
        step(1'b1, 1'b0, 32'd0);
        clear_got();
        feed('{1, 2, 3, 4, 5, 6, 7, 8}, 3);
        idle(3);
        chk_list("gapped w4", 0, '{6, 8});

        // odd width 5: trailing column ignored
        step(1'b1, 1'b0, 32'd0);
        clear_got();
        feed('{1, 2, 3, 4, 9, 5, 6, 7, 8, 9}, 0);
        idle(3);
        chk_list("odd w5", 2, '{6, 8});

        // requantization on width 2
        four(100, -4, 3, 12, "rq bias");
        four(20, 0, 3, 3, "rq round");
        four(-50, 0, 3, 0, "rq relu");
        four(100000, 0, 0, 255, "rq sat");
        bias = 16'sd0; shift = 5'd0;

        // mid-frame frame_start, then frame_start coincident with first sample
        step(1'b1, 1'b0, 32'd0);
        clear_got();
        feed('{1, 2, 3}, 0);
        step(1'b1, 1'b1, 32'd1);
        feed('{2, 3, 4, 5, 6, 7, 8}, 0);
        idle(3);
        chk_list("restart w4", 0, '{6, 8});

        // reset while an output is showing in the odd row
        step(1'b1, 1'b0, 32'd0);
        feed('{1, 2, 3, 4, 5, 6, 7}, 0);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("async rst");
        stg_v = 1'b0;
        model_clear();
        clear_got();
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);
        feed('{1, 2, 3, 4, 5, 6, 7, 8}, 0);
        idle(3);
        chk_list("post rst w4", 0, '{6, 8});

        // randomized frames against the model
        for (int f = 0; f < 8; f++) begin
            int n;
            bias  = 16'($urandom_range(0, 4000)) - 16'sd2000;
            shift = 5'($urandom_range(0, 12));
            n     = $urandom_range(8, 40);
            if ($urandom_range(0, 1) == 0) begin
                step(1'b1, 1'b0, 32'd0);
            end else begin
                step(1'b1, 1'b1, $urandom_range(0, 60000) - 32'd20000);
            end
            for (int i = 0; i < n; i++) begin
                idle($urandom_range(0, 2));
                case ($urandom_range(0, 7))
                    0:       step(1'b0, 1'b1, $urandom);
                    1:       step(1'b0, 1'b1, 32'h7fff_ffff);
                    default: step(1'b0, 1'b1, $urandom_range(0, 60000) - 32'd20000);
                endcase
            end
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
